debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 8: number of independent input channels, range 1..32.
REQ-002 Parameter CNT_W, default 8: stability counter and threshold width, range 2..16.
REQ-003 Parameter RST_LEVEL, default all-ones [N_CH]: per-channel filtered output level at reset, deasserted for active-low inputs.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_raw  input  N_CH  asynchronous, possibly glitchy channel inputs.
REQ-007 cfg_en  input  N_CH  per-channel filter enable; 0 = bypass.
REQ-008 cfg_th_rise  input  CNT_W  stable samples required to commit a 0->1 transition.
REQ-009 cfg_th_fall  input  CNT_W  stable samples required to commit a 1->0 transition.
REQ-010 out  output  N_CH  filtered levels, registered.
REQ-011 rise_pulse  output  N_CH  one-cycle pulse on a committed 0->1 transition.
REQ-012 fall_pulse  output  N_CH  one-cycle pulse on a committed 1->0 transition.
REQ-013 chg_sticky  output  N_CH  sticky flag, set on any committed transition.
REQ-014 chg_clr  input  N_CH  per-channel clear of chg_sticky.

Function
REQ-015 Each in_raw bit SHALL pass a 2-flop synchronizer; sync[i] SHALL be in_raw[i] delayed 2 clocks.
REQ-016 Per channel, effective threshold T SHALL be cfg_th_rise when out[i]=0 and cfg_th_fall when out[i]=1; a value of 0 SHALL be treated as 1.
REQ-017 When sync[i]==out[i], cnt[i] SHALL load 0.
REQ-018 When sync[i]!=out[i] and cnt[i]+1<T, cnt[i] SHALL increment by 1.
REQ-019 When sync[i]!=out[i] and cnt[i]+1>=T, out[i] SHALL load sync[i], cnt[i] SHALL load 0, and the matching pulse SHALL assert for the next cycle only.
REQ-020 Latency: a raw change held stable from edge k SHALL appear on out at edge k+2+T; any reverting sample before then SHALL discard progress, leaving out unchanged.
REQ-021 Thresholds SHALL be sampled every cycle; lowering T mid-count so that cnt+1>=T SHALL commit on the next differing sample.
REQ-022 cfg_en[i]=0 SHALL set out[i]<=sync[i] every cycle with cnt[i]=0; pulses and sticky SHALL still report changes.
REQ-023 The counter SHALL never exceed 2^CNT_W-1; no wrap-around.
REQ-024 chg_sticky[i] SHALL set on a commit and clear on chg_clr[i]; set SHALL win over a simultaneous clear.
REQ-025 Channels SHALL be fully independent; simultaneous commits on several channels SHALL all be reported in the same cycle.

Reset
REQ-026 During rst_n=0: out=RST_LEVEL, synchronizer flops=RST_LEVEL, cnt=0, rise_pulse=fall_pulse=0, chg_sticky=0.
REQ-027 Reset assertion mid-count SHALL discard progress immediately without generating a pulse.
REQ-028 Reset release SHALL NOT generate a pulse even if in_raw differs from RST_LEVEL; normal qualification SHALL follow.

Structure
REQ-029 Package debounce_pkg SHALL hold the CNT_W default, the threshold clamp function and the synchronizer depth constant (2).
REQ-030 Per-channel logic (synchronizer, counter, commit, pulses, sticky) SHALL be sub-module debounce_chan, instantiated N_CH times by generate.

Verification
REQ-031 Clean step: th_rise=4, ch0 in_raw 1->0 held, th_fall=4 -> out[0] falls exactly 6 cycles later; fall_pulse[0] high 1 cycle.
REQ-032 Glitch reject: th_fall=4, ch0 low for 3 cycles then high -> out[0] stays 1, no pulse, sticky stays 0.
REQ-033 Asymmetry: th_rise=2, th_fall=10 -> fall commits after 12 cycles, rise after 4; pulses correct.
REQ-034 Bypass: cfg_en[3]=0, 1-cycle pulse on in_raw[3] -> out[3] pulses 1 cycle, 2 cycles late; rise and fall pulses both seen.
REQ-035 Sticky race: commit and chg_clr same cycle -> sticky=1; clear next cycle -> sticky=0.
REQ-036 Reset mid-count: th=8, assert rst_n at count 5 -> out=RST_LEVEL, no pulse; after release, a new full 8-sample qualification is required.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce bank.
// Threshold clamp keeps a zero threshold behaving as one sample.
package debounce_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int SYNC_DEPTH = 2;

  function automatic logic [15:0] th_clamp(input logic [15:0] th);
    return (th == 16'd0) ? 16'd1 : th;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchronizer, stability counter, commit,
// edge pulses and sticky change flag.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   CNT_W     = CNT_W_DEF,
  parameter logic RST_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_raw,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_th_rise,
  input  logic [CNT_W-1:0] cfg_th_fall,
  input  logic             chg_clr,
  output logic             out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             chg_sticky
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [CNT_W-1:0]      th_sel;
  logic [16:0]           th_eff;
  logic [16:0]           cnt_nxt;
  logic                  commit;

  assign sync    = sync_q[SYNC_DEPTH-1];
  assign th_sel  = out ? cfg_th_fall : cfg_th_rise;
  assign th_eff  = {1'b0, th_clamp(16'(th_sel))};
  assign cnt_nxt = 17'(cnt_q) + 17'd1;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_DEPTH{RST_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], in_raw};
    end
  end

  // Decide whether to count, restart, or commit the new level.
  always_comb begin
    cnt_d  = '0;
    commit = 1'b0;
    if (sync != out) begin
      if (!cfg_en || cnt_nxt >= th_eff) begin
        commit = 1'b1;
      end else begin
        cnt_d = cnt_nxt[CNT_W-1:0];
      end
    end
  end

  // Register level, counter, pulses and sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      out        <= RST_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      chg_sticky <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      out        <= commit ? sync : out;
      rise_pulse <= commit & sync;
      fall_pulse <= commit & ~sync;
      chg_sticky <= commit | (chg_sticky & ~chg_clr);
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels sharing one threshold pair.
// Every channel is a separate debounce_chan instance.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int              N_CH      = 8,
  parameter int              CNT_W     = CNT_W_DEF,
  parameter logic [N_CH-1:0] RST_LEVEL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  in_raw,
  input  logic [N_CH-1:0]  cfg_en,
  input  logic [CNT_W-1:0] cfg_th_rise,
  input  logic [CNT_W-1:0] cfg_th_fall,
  output logic [N_CH-1:0]  out,
  output logic [N_CH-1:0]  rise_pulse,
  output logic [N_CH-1:0]  fall_pulse,
  output logic [N_CH-1:0]  chg_sticky,
  input  logic [N_CH-1:0]  chg_clr
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_chan #(
      .CNT_W     (CNT_W),
      .RST_LEVEL (RST_LEVEL[g])
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_raw      (in_raw[g]),
      .cfg_en      (cfg_en[g]),
      .cfg_th_rise (cfg_th_rise),
      .cfg_th_fall (cfg_th_fall),
      .chg_clr     (chg_clr[g]),
      .out         (out[g]),
      .rise_pulse  (rise_pulse[g]),
      .fall_pulse  (fall_pulse[g]),
      .chg_sticky  (chg_sticky[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Scenario bench for debounce_bank with a per-cycle
// expectation queue.
module tb_debounce_bank;

  localparam int N = 8;
  localparam int W = 8;

  typedef struct packed {
    logic [N-1:0] o;
    logic [N-1:0] r;
    logic [N-1:0] f;
    logic [N-1:0] s;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in_raw;
  logic [N-1:0] cfg_en;
  logic [W-1:0] cfg_th_rise;
  logic [W-1:0] cfg_th_fall;
  logic [N-1:0] out;
  logic [N-1:0] rise_pulse;
  logic [N-1:0] fall_pulse;
  logic [N-1:0] chg_sticky;
  logic [N-1:0] chg_clr;

  exp_t         sb[$];
  exp_t         got;
  logic [N-1:0] e_out;
  logic [N-1:0] e_st;
  int           checks = 0;
  int           failures = 0;

  debounce_bank #(.N_CH(N), .CNT_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_raw      (in_raw),
    .cfg_en      (cfg_en),
    .cfg_th_rise (cfg_th_rise),
    .cfg_th_fall (cfg_th_fall),
    .out         (out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .chg_sticky  (chg_sticky),
    .chg_clr     (chg_clr)
  );

  always #5 clk = ~clk;

  assign got = {out, rise_pulse, fall_pulse, chg_sticky};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    in_raw      = '1;
    cfg_en      = '1;
    cfg_th_rise = 8'd4;
    cfg_th_fall = 8'd4;
    repeat (20) tick();
    chg_clr = '1;
    tick();
    chg_clr = '0;
    e_out = '1;
    e_st  = '0;
  endtask

  task automatic test_reset();
    exp_t x;
    rst_n       = 1'b0;
    in_raw      = '1;
    cfg_en      = '1;
    cfg_th_rise = 8'd4;
    cfg_th_fall = 8'd4;
    chg_clr     = '0;
    e_out = '1;
    e_st  = '0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) rst_n = 1'b1;
      x = '{o: e_out, r: '0, f: '0, s: e_st};
      sb.push_back(x);
      tick();
      x = sb.pop_front();
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL reset c=%0d got=%h exp=%h", c, got, x);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t x;
    cfg_th_fall = 8'd4;
    in_raw[0]   = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      x = '{o: e_out, r: '0, f: '0, s: e_st};
      sb.push_back(x);
      tick();
      x = sb.pop_front();
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL glitch e=%0d got=%h exp=%h", e, got, x);
      end
      if (e == 3) in_raw[0] = 1'b1;
    end
  endtask

  task automatic test_clean_step();
    exp_t x;
    cfg_th_rise = 8'd4;
    cfg_th_fall = 8'd4;
    in_raw[0]   = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      x = '{o: e_out, r: '0, f: '0, s: e_st};
      if (e == 6) begin
        e_out[0] = 1'b0;
        e_st[0]  = 1'b1;
        x.o = e_out;
        x.s = e_st;
        x.f[0] = 1'b1;
      end
      sb.push_back(x);
      tick();
      x = sb.pop_front();
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL clean_step e=%0d got=%h exp=%h", e, got, x);
      end
    end
  endtask

  task automatic test_asymmetry();
    exp_t x;
    cfg_th_rise = 8'd2;
    cfg_th_fall = 8'd10;
    in_raw[0]   = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      x = '{o: e_out, r: '0, f: '0, s: e_st};
      if (e == 4) begin
        e_out[0] = 1'b1;
        x.o = e_out;
        x.r[0] = 1'b1;
      end
      sb.push_back(x);
      tick();
      x = sb.pop_front();
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL asym_rise e=%0d got=%h exp=%h", e, got, x);
      end
    end
    in_raw[0] = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      x = '{o: e_out, r: '0, f: '0, s: e_st};
      if (e == 12) begin
        e_out[0] = 1'b0;
        x.o = e_out;
        x.f[0] = 1'b1;
      end
      sb.push_back(x);
      tick();
      x = sb.pop_front();
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL asym_fall e=%0d got=%h exp=%h", e, got, x);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t x;
    cfg_en[3] = 1'b0;
    in_raw[3] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      x = '{o: e_out, r: '0, f: '0, s: e_st};
      if (e == 3) begin
        e_out[3] = 1'b0;
        e_st[3]  = 1'b1;
        x.f[3] = 1'b1;
      end
      if (e == 4) begin
        e_out[3] = 1'b1;
        x.r[3] = 1'b1;
      end
      x.o = e_out;
      x.s = e_st;
      sb.push_back(x);
      tick();
      x = sb.pop_front();
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL bypass e=%0d got=%h exp=%h", e, got, x);
      end
      if (e == 1) in_raw[3] = 1'b1;
    end
    cfg_en[3] = 1'b1;
  endtask

  task automatic test_sticky_race();
    exp_t x;
    in_raw[1] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      x = '{o: e_out, r: '0, f: '0, s: e_st};
      if (e == 6) begin
        e_out[1] = 1'b0;
        e_st[1]  = 1'b1;
        x.f[1] = 1'b1;
      end
      if (e == 7) e_st[1] = 1'b0;
      x.o = e_out;
      x.s = e_st;
      sb.push_back(x);
      tick();
      x = sb.pop_front();
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL sticky_race e=%0d got=%h exp=%h", e, got, x);
      end
      if (e == 5) chg_clr[1] = 1'b1;
      if (e == 7) chg_clr[1] = 1'b0;
    end
  endtask

  task automatic test_reset_midcount();
    exp_t x;
    cfg_th_rise = 8'd8;
    cfg_th_fall = 8'd8;
    in_raw[2]   = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      x = '{o: e_out, r: '0, f: '0, s: e_st};
      sb.push_back(x);
      tick();
      x = sb.pop_front();
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL midcount_pre e=%0d got=%h exp=%h", e, got, x);
      end
    end
    rst_n = 1'b0;
    e_out = '1;
    e_st  = '0;
    x = '{o: e_out, r: '0, f: '0, s: e_st};
    sb.push_back(x);
    #1;
    x = sb.pop_front();
    checks++;
    if (got !== x) begin
      failures++;
      $display("FAIL midcount_rst got=%h exp=%h", got, x);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int r = 1; r <= 11; r++) begin
      x = '{o: e_out, r: '0, f: '0, s: e_st};
      if (r == 10) begin
        e_out[2] = 1'b0;
        e_st[2]  = 1'b1;
        x.o = e_out;
        x.s = e_st;
        x.f[2] = 1'b1;
      end
      sb.push_back(x);
      tick();
      x = sb.pop_front();
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL midcount_post r=%0d got=%h exp=%h", r, got, x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_step();
    test_asymmetry();
    settle();
    test_bypass();
    settle();
    test_sticky_race();
    settle();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
